transmitter: RTL and testbench
==============================

TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1, legal range 1..65535: clock cycles per serial bit.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port arst, input, 1 bit: reset, synchronous and active-high (the port keeps the codebase name arst).
REQ-005 SHALL have port data_in, input, DATA_WIDTH bits: byte to send, sampled only on accept.
REQ-006 SHALL have port valid, input, 1 bit: data_in holds a byte to send.
REQ-007 SHALL have port ready, output, 1 bit: the block can accept a byte this cycle.
REQ-008 SHALL have port out, output, 1 bit: serial line, idle high, feeds the receiver's in.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-011 SHALL transfer a byte on a rising edge where valid=1 and ready=1 (accept); data_in is latched internally at that edge.
REQ-012 SHALL send the frame in this order: start bit (0), DATA_WIDTH data bits LSB first, even-parity bit (XOR of all data bits), stop bit (1). This is DATA_WIDTH+3 bits.
REQ-013 SHALL hold each frame bit on out for exactly CLKS_PER_BIT cycles.
REQ-014 SHALL drive the start bit on out starting at the first edge after accept (latency 1 cycle).
REQ-015 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP.
  - IDLE->START on accept.
  - START->DATA, DATA->PARITY (after the last data bit) and PARITY->STOP each occur when the baud counter expires.
  - STOP->IDLE when the counter expires and there is no accept.
  - STOP->START when the counter expires and there is an accept.
REQ-016 SHALL drive ready=1 in IDLE and in the final cycle of STOP; ready SHALL be 0 otherwise. Consequently back-to-back frames have no idle gap.
REQ-017 SHALL drive busy=1 in every state except IDLE.
REQ-018 SHALL assert done for exactly one cycle, in the final cycle of STOP, whether or not the next frame is accepted.
REQ-019 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1 and wraps; it restarts at 0 on every state change.
REQ-020 SHALL use a bit index that runs 0..DATA_WIDTH-1 in DATA and SHALL NOT wrap within a frame.
REQ-021 SHALL ignore valid while ready=0; data_in changes mid-frame SHALL NOT affect the frame being sent.
REQ-022 SHALL, with CLKS_PER_BIT=1, keep each state for one cycle and hold DATA for DATA_WIDTH cycles.

Reset
REQ-023 SHALL, when arst=1 at an edge, set state=IDLE, out=1, ready=1, busy=0, done=0 and zero all counters.
REQ-024 SHALL abandon any frame in progress on reset mid-frame: out SHALL be 1 from the next edge on and SHALL NOT produce a done pulse.
REQ-025 SHALL give arst priority over an accept in the same cycle; the byte is dropped.

Structure
REQ-026 SHALL take the state enum and the frame constants (START_BIT=0, STOP_BIT=1, FRAME_BITS=DATA_WIDTH+3) from the shared package transceiver_pkg, which the receiver also uses.
REQ-027 SHALL put the baud counter in one sub-module, baud_gen. baud_gen takes CLKS_PER_BIT, a clear input and a tick output.
REQ-028 SHALL be implemented in at most 400 lines of RTL, with no latches and all outputs registered.

Verification
REQ-029 Single frame, CLKS_PER_BIT=1: data_in=8'hA5 accepted at cycle 0 -> out over cycles 1..11 = 0,1,0,1,0,0,1,0,1,0,1; done=1 in cycle 11 only.
REQ-030 Baud stretch, CLKS_PER_BIT=4: data_in=8'h01 -> every bit lasts 4 cycles; parity=1; the frame is 44 cycles; busy is high throughout.
REQ-031 Back-to-back: valid held high with 8'h00 then 8'hFF -> the second start bit directly follows the first stop bit with no idle cycle; parities are 0 and 0.
REQ-032 Reset mid-frame: arst=1 during DATA bit 3 -> out=1, ready=1, busy=0 on the next edge; no done; the next accept then sends a correct full frame.
REQ-033 Loopback: out connected to the receiver, then the decoder, for 256 random bytes -> decoder err=0 and out_byte equals the sent byte each time.
REQ-034 Stall: valid=1 while busy, with data_in changing every cycle -> the transmitted bits match only the byte latched at accept.

Source files
------------

// File: rtl/transceiver_pkg.sv
// Shared serial framing definitions.
// Used by the transmitter and the receiver.
package transceiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   FRAME_EXTRA = 3;

  // start + data + parity + stop
  function automatic int frame_bits(input int data_width);
    return data_width + FRAME_EXTRA;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and wraps.
// tick marks the last cycle of a bit; tick_next predicts it.
module baud_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt + 1'b1;
    if (clear || cnt == LAST) cnt_n = '0;
  end

  always_ff @(posedge clk) begin
    cnt <= cnt_n;
  end

  assign tick      = (cnt == LAST);
  assign tick_next = (cnt_n == LAST);

endmodule

// File: rtl/transmitter.sv
// Serial frame transmitter: start, data LSB first,
// even parity, stop. All outputs registered.
module transmitter
  import transceiver_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  out,
  output logic                  busy,
  output logic                  done
);

  localparam int IW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  parity_q;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic                  accept;
  logic                  tick;
  logic                  tick_next;
  logic                  clear;
  logic                  out_n;
  logic                  last_stop_n;

  assign accept = valid & ready;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        if (accept) state_n = START;
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == IDX_LAST) state_n = PARITY;
          else                 idx_n   = idx + 1'b1;
        end
      end
      PARITY: begin
        if (tick) state_n = STOP;
      end
      STOP: begin
        if (tick) state_n = accept ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Restart the bit timer on every state change and on reset.
  assign clear = arst | (state_n != state);

  baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .clear     (clear),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    out_n = STOP_BIT;
    unique case (state_n)
      IDLE:    out_n = STOP_BIT;
      START:   out_n = START_BIT;
      DATA:    out_n = data_q[idx_n];
      PARITY:  out_n = parity_q;
      STOP:    out_n = STOP_BIT;
      default: out_n = STOP_BIT;
    endcase
  end

  // Outputs look one cycle ahead so they are registered.
  assign last_stop_n = (state_n == STOP) && tick_next;

  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= IDLE;
      idx      <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      out      <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (accept) begin
        data_q   <= data_in;
        parity_q <= ^data_in;
      end
      out   <= out_n;
      ready <= (state_n == IDLE) || last_stop_n;
      busy  <= (state_n != IDLE);
      done  <= last_stop_n;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for the serial transmitter.
// Two instances: one bit per cycle and four cycles per bit.
module tb_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst;
  logic       valid;
  logic [7:0] data_in;
  logic       ready;
  logic       out;
  logic       busy;
  logic       done;

  logic       arst_b;
  logic       valid_b;
  logic [7:0] data_b;
  logic       ready_b;
  logic       out_b;
  logic       busy_b;
  logic       done_b;

  transmitter #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (1)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  transmitter #(
    .DATA_WIDTH   (8),
    .CLKS_PER_BIT (4)
  ) dut_b (
    .clk     (clk),
    .arst    (arst_b),
    .data_in (data_b),
    .valid   (valid_b),
    .ready   (ready_b),
    .out     (out_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame bit i of byte d, straight from the frame format.
  function automatic logic fbit(input logic [7:0] d,
                                input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9) return ^d;
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[5];

  logic       log_q[$];
  logic [7:0] exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int dones;
    int cyc;
    int nframes;
    int i;
    logic [7:0] b;
    logic [7:0] e;
    logic err;

    // serial order, first bit in the MSB
    vecs[0] = '{8'hA5, 11'b0_10100101_0_1};
    vecs[1] = '{8'h00, 11'b0_00000000_0_1};
    vecs[2] = '{8'hFF, 11'b0_11111111_0_1};
    vecs[3] = '{8'h01, 11'b0_10000000_1_1};
    vecs[4] = '{8'h80, 11'b0_00000001_1_1};

    arst = 1'b1; valid = 1'b0; data_in = '0;
    arst_b = 1'b1; valid_b = 1'b0; data_b = '0;
    step();
    step();
    check("rst out", out, 1'b1);
    check("rst ready", ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst_b out", out_b, 1'b1);
    check("rst_b ready", ready_b, 1'b1);
    check("rst_b busy", busy_b, 1'b0);
    arst = 1'b0;
    arst_b = 1'b0;
    step();

    // table-driven single frames
    for (int v = 0; v < 5; v++) begin
      data_in = vecs[v].data;
      valid = 1'b1;
      step();
      valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
        check($sformatf("vec%0d out c%0d", v, c),
              out, vecs[v].frame[11-c]);
        check($sformatf("vec%0d done c%0d", v, c),
              done, c == 11);
        check($sformatf("vec%0d ready c%0d", v, c),
              ready, c == 11);
        check($sformatf("vec%0d busy c%0d", v, c),
              busy, 1'b1);
        step();
      end
      check($sformatf("vec%0d idle out", v), out, 1'b1);
      check($sformatf("vec%0d idle busy", v), busy, 1'b0);
      check($sformatf("vec%0d idle ready", v), ready, 1'b1);
      check($sformatf("vec%0d idle done", v), done, 1'b0);
    end

    // back-to-back 00 then FF, valid held high
    data_in = 8'h00;
    valid = 1'b1;
    step();
    for (int c = 1; c <= 22; c++) begin
      logic eb;
      eb = (c <= 11) ? fbit(8'h00, c - 1)
                     : fbit(8'hFF, c - 12);
      check($sformatf("b2b out c%0d", c), out, eb);
      check($sformatf("b2b busy c%0d", c), busy, 1'b1);
      check($sformatf("b2b done c%0d", c),
            done, (c == 11) || (c == 22));
      if (c == 11) data_in = 8'hFF;
      if (c == 12) valid = 1'b0;
      step();
    end
    check("b2b end busy", busy, 1'b0);
    check("b2b end ready", ready, 1'b1);

    // stall: data_in churns while the frame is sent
    data_in = 8'h5A;
    valid = 1'b1;
    step();
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("stall out c%0d", c),
            out, fbit(8'h5A, c - 1));
      data_in = 8'($urandom);
      valid = (c < 11);
      step();
    end
    check("stall end busy", busy, 1'b0);

    // reset during data bit 3
    data_in = 8'hC3;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c < 5; c++) step();
    check("mid out bit3", out, fbit(8'hC3, 4));
    check("mid busy", busy, 1'b1);
    arst = 1'b1;
    step();
    arst = 1'b0;
    check("mid rst out", out, 1'b1);
    check("mid rst ready", ready, 1'b1);
    check("mid rst busy", busy, 1'b0);
    check("mid rst done", done, 1'b0);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("mid quiet done c%0d", c), done, 1'b0);
      check($sformatf("mid quiet out c%0d", c), out, 1'b1);
      step();
    end
    data_in = 8'h96;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("post rst out c%0d", c),
            out, fbit(8'h96, c - 1));
      check($sformatf("post rst done c%0d", c), done, c == 11);
      step();
    end

    // reset wins over an accept in the same cycle
    arst = 1'b1;
    valid = 1'b1;
    data_in = 8'h00;
    step();
    arst = 1'b0;
    valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("rst prio out c%0d", c), out, 1'b1);
      check($sformatf("rst prio busy c%0d", c), busy, 1'b0);
      step();
    end

    // four cycles per bit
    data_b = 8'h01;
    valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      check($sformatf("slow out c%0d", c),
            out_b, fbit(8'h01, (c - 1) / 4));
      check($sformatf("slow busy c%0d", c), busy_b, 1'b1);
      check($sformatf("slow done c%0d", c), done_b, c == 44);
      step();
    end
    check("slow end busy", busy_b, 1'b0);
    check("slow end out", out_b, 1'b1);

    // random loopback: record the line, decode afterwards
    accepted = 0;
    dones = 0;
    cyc = 0;
    while (accepted < 256 && cyc < 8000) begin
      valid = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      if (valid && ready) begin
        exp_q.push_back(data_in);
        accepted++;
      end
      step();
      log_q.push_back(out);
      if (done) dones++;
      cyc++;
    end
    valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      log_q.push_back(out);
      if (done) dones++;
    end
    check("loop accepted", accepted, 256);
    check("loop dones", dones, 256);

    nframes = 0;
    i = 0;
    while (i < log_q.size()) begin
      if (log_q[i] == 1'b0) begin
        if (i + 10 >= log_q.size()) begin
          check("loop truncated", 1, 0);
          break;
        end
        for (int k = 0; k < 8; k++) b[k] = log_q[i+1+k];
        err = (log_q[i+9] != ^b) || (log_q[i+10] != 1'b1);
        check($sformatf("loop err f%0d", nframes), err, 1'b0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("loop byte f%0d", nframes), b, e);
        end else begin
          check("loop extra frame", 1, 0);
        end
        nframes++;
        i += 11;
      end else begin
        i++;
      end
    end
    check("loop frames", nframes, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
